// File: rtl/branch_pkg.sv
// branch_pkg: shared flag position, record types and branch condition helper
package branch_pkg;
  localparam int FLAG_TAKEN = 5;
  localparam int BR_DATA_W = 8;
  localparam int BR_TAG_W = 4;
  localparam int BR_ROBID_W = 4;
  typedef struct packed {
    logic [BR_TAG_W-1:0]  tag;
    logic [BR_DATA_W-1:0] val;
  } cdb_rec_t;
  typedef struct packed {
    logic [BR_ROBID_W-1:0] robid;
    logic [BR_DATA_W-1:0]  flags;
    logic [BR_DATA_W-1:0]  wbs;
    logic [BR_DATA_W-1:0]  val;
  } rob_rec_t;
  function automatic logic branch_take(input logic [3:0] mask, input logic neg, input logic nz);
    return mask[{neg, nz}];
  endfunction
endpackage

// File: rtl/fu_out_fifo.sv
// fu_out_fifo: DEPTH-entry in-order record queue with clear and head peek
module fu_out_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_d = clr ? '0 : push ? (wr_q == PW'(DEPTH-1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d = clr ? '0 : pop ? (rd_q == PW'(DEPTH-1) ? '0 : rd_q + PW'(1)) : rd_q;
    count_d = clr ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_q] <= din;
  end
  assign head = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/branch_unit.sv
// branch_unit: evaluates branch condition and delivers CDB and ROB records through bypassable queues
module branch_unit
  import branch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAG_W = 4,
  parameter int ROBID_W = 4,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   input_transmit,
  input  logic [DATA_W-1:0]      operand,
  input  logic [1:0][DATA_W-1:0] depvals,
  input  logic [DATA_W-1:0]      wbs,
  input  logic [DATA_W-1:0]      flags,
  input  logic [ROBID_W-1:0]     robid,
  input  logic                   cdb_transmit,
  output logic                   cdb_transmit_out,
  output logic [TAG_W-1:0]       cdb_id,
  output logic [DATA_W-1:0]      cdb_val,
  input  logic                   rob_transmit,
  output logic                   rob_transmit_out,
  output logic [ROBID_W-1:0]     robid_out,
  output logic [DATA_W-1:0]      flags_out,
  output logic [DATA_W-1:0]      wbs_out,
  output logic [DATA_W-1:0]      value_out,
  output logic                   busy
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int CDB_W = TAG_W + DATA_W;
  localparam int ROB_W = ROBID_W + 3*DATA_W;
  logic [DATA_W-1:0] a, b, flags_upd;
  logic issue, cdb_req, rob_req, cdb_grant, rob_grant, cdb_empty, rob_empty;
  logic cdb_push, cdb_pop, rob_push, rob_pop, unused_ok;
  logic [CW-1:0] cdb_count, rob_count;
  logic [CDB_W-1:0] cdb_live, cdb_head;
  logic [ROB_W-1:0] rob_live, rob_head;
  always_comb begin
    a = depvals[0];
    b = depvals[1];
    flags_upd = flags;
    flags_upd[FLAG_TAKEN] = branch_take(operand[7:4], a[DATA_W-1], |a[DATA_W-2:0]);
    busy = cdb_count == CW'(DEPTH) || rob_count == CW'(DEPTH);
    issue = input_transmit & ~busy & ~flush & ~rst;
    cdb_empty = cdb_count == '0;
    rob_empty = rob_count == '0;
    cdb_req = ~rst & ~flush & (~cdb_empty | issue);
    rob_req = ~rst & ~flush & (~rob_empty | issue);
    cdb_grant = cdb_req & ~cdb_transmit;
    rob_grant = rob_req & ~rob_transmit;
    cdb_transmit_out = cdb_transmit | cdb_req;
    rob_transmit_out = rob_transmit | rob_req;
    cdb_live = {wbs[TAG_W-1:0], b};
    rob_live = {robid, flags_upd, wbs, b};
    cdb_push = issue & ~(cdb_grant & cdb_empty);
    rob_push = issue & ~(rob_grant & rob_empty);
    cdb_pop = cdb_grant & ~cdb_empty;
    rob_pop = rob_grant & ~rob_empty;
    {cdb_id, cdb_val} = cdb_grant ? (cdb_empty ? cdb_live : cdb_head) : '0;
    {robid_out, flags_out, wbs_out, value_out} = rob_grant ? (rob_empty ? rob_live : rob_head) : '0;
  end
  assign unused_ok = ^operand[3:0];
  fu_out_fifo #(.W(CDB_W), .DEPTH(DEPTH)) u_cdb_q (
    .clk(clk), .rst(rst), .clr(flush), .push(cdb_push), .pop(cdb_pop),
    .din(cdb_live), .head(cdb_head), .count(cdb_count)
  );
  fu_out_fifo #(.W(ROB_W), .DEPTH(DEPTH)) u_rob_q (
    .clk(clk), .rst(rst), .clr(flush), .push(rob_push), .pop(rob_pop),
    .din(rob_live), .head(rob_head), .count(rob_count)
  );
  always_ff @(posedge clk) begin
    if (!rst) assert (!(input_transmit && busy)) else $warning("branch_unit: issue while busy dropped");
  end
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: scoreboard bench for branch_unit
module tb_branch_unit;
  import branch_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1, flush = 0, input_transmit = 0, cdb_transmit = 0, rob_transmit = 0;
  logic [7:0] operand = '0, wbs = '0, flags = '0;
  logic [1:0][7:0] depvals = '0;
  logic [3:0] robid = '0;
  logic cdb_transmit_out, rob_transmit_out, busy;
  logic [3:0] cdb_id, robid_out;
  logic [7:0] cdb_val, flags_out, wbs_out, value_out;
  cdb_rec_t cdb_sb[$];
  rob_rec_t rob_sb[$];
  cdb_rec_t e_cdb;
  rob_rec_t e_rob;
  logic e_ctx, e_rtx, e_busy;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  branch_unit #(.DATA_W(8), .TAG_W(4), .ROBID_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .input_transmit(input_transmit),
    .operand(operand), .depvals(depvals), .wbs(wbs), .flags(flags), .robid(robid),
    .cdb_transmit(cdb_transmit), .cdb_transmit_out(cdb_transmit_out),
    .cdb_id(cdb_id), .cdb_val(cdb_val),
    .rob_transmit(rob_transmit), .rob_transmit_out(rob_transmit_out),
    .robid_out(robid_out), .flags_out(flags_out), .wbs_out(wbs_out),
    .value_out(value_out), .busy(busy)
  );
  task automatic cycle(input logic r, input logic fl, input logic it, input logic ctx, input logic rtx,
                       input logic [7:0] a, input logic [3:0] m, input logic [7:0] b,
                       input logic [7:0] w, input logic [7:0] f, input logic [3:0] id);
    logic [1:0] idx;
    logic tk, acc;
    @(posedge clk);
    if (rst || flush) begin
      cdb_sb.delete();
      rob_sb.delete();
    end
    #1;
    rst = r;
    flush = fl;
    input_transmit = it;
    cdb_transmit = ctx;
    rob_transmit = rtx;
    operand = {m, 4'($urandom)};
    depvals[0] = a;
    depvals[1] = b;
    wbs = w;
    flags = f;
    robid = id;
    e_busy = cdb_sb.size() == DEPTH || rob_sb.size() == DEPTH;
    acc = it && !fl && !r && !e_busy;
    idx = {a[7], a[6:0] != 7'd0};
    tk = m[idx];
    if (acc) begin
      cdb_sb.push_back({w[3:0], b});
      rob_sb.push_back({id, f[7:6], tk, f[4:0], w, b});
    end
    e_ctx = ctx || (!r && !fl && cdb_sb.size() > 0);
    e_rtx = rtx || (!r && !fl && rob_sb.size() > 0);
    e_cdb = '0;
    e_rob = '0;
    if (!ctx && e_ctx) e_cdb = cdb_sb.pop_front();
    if (!rtx && e_rtx) e_rob = rob_sb.pop_front();
    @(negedge clk);
  endtask
  task automatic idle(input logic ctx, input logic rtx);
    cycle(0, 0, 0, ctx, rtx, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0);
  endtask
  task automatic test_reset;
    cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0);
    cycle(1, 1, 1, 0, 0, 8'h00, 4'h1, 8'h55, 8'h01, 8'h00, 4'h1);
    idle(0, 0);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (cdb_transmit_out !== 1'b0) $display("FAIL reset_cdb_tx got %b want 0", cdb_transmit_out); else passed++;
    total++; if (rob_transmit_out !== 1'b0) $display("FAIL reset_rob_tx got %b want 0", rob_transmit_out); else passed++;
    total++; if ({cdb_id, cdb_val, value_out} !== 20'h0) $display("FAIL reset_data got %h want 0", {cdb_id, cdb_val, value_out}); else passed++;
    idle(1, 1);
    total++; if ({cdb_transmit_out, rob_transmit_out} !== 2'b11) $display("FAIL reset_upstream_tx got %b want 11", {cdb_transmit_out, rob_transmit_out}); else passed++;
  endtask
  task automatic test_taken;
    cycle(0, 0, 1, 0, 0, 8'h00, 4'b0001, 8'h42, 8'h03, 8'h00, 4'd5);
    total++; if ({cdb_id, cdb_val} !== 12'h342) $display("FAIL taken_cdb got %h want 342", {cdb_id, cdb_val}); else passed++;
    total++; if (flags_out !== 8'h20) $display("FAIL taken_flags got %h want 20", flags_out); else passed++;
    total++; if ({robid_out, wbs_out, value_out} !== 20'h50342) $display("FAIL taken_rob got %h want 50342", {robid_out, wbs_out, value_out}); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL taken_busy got %b want 0", busy); else passed++;
    idle(0, 0);
    total++; if ({busy, cdb_transmit_out, rob_transmit_out} !== 3'b000) $display("FAIL taken_after got %b want 000", {busy, cdb_transmit_out, rob_transmit_out}); else passed++;
  endtask
  task automatic test_not_taken;
    cycle(0, 0, 1, 0, 0, 8'h85, 4'b0111, 8'h42, 8'h03, 8'hff, 4'd5);
    total++; if (flags_out !== 8'hdf) $display("FAIL neg_nz_flags got %h want df", flags_out); else passed++;
    cycle(0, 0, 1, 0, 0, 8'h80, 4'b0100, 8'h10, 8'h07, 8'h00, 4'd2);
    total++; if (flags_out !== 8'h20) $display("FAIL neg_zero_flags got %h want 20", flags_out); else passed++;
    cycle(0, 0, 1, 0, 0, 8'h01, 4'b1101, 8'h10, 8'h07, 8'h21, 4'd2);
    total++; if (flags_out !== 8'h01) $display("FAIL pos_nz_flags got %h want 01", flags_out); else passed++;
  endtask
  task automatic test_cdb_stall;
    cycle(0, 0, 1, 1, 0, 8'h00, 4'hf, 8'h11, 8'h01, 8'h00, 4'd1);
    total++; if ({rob_transmit_out, robid_out, value_out} !== 13'h1111) $display("FAIL stall_rob0 got %h want 1111", {rob_transmit_out, robid_out, value_out}); else passed++;
    total++; if ({cdb_transmit_out, cdb_id, cdb_val} !== 13'h1000) $display("FAIL stall_cdb0 got %h want 1000", {cdb_transmit_out, cdb_id, cdb_val}); else passed++;
    cycle(0, 0, 1, 1, 0, 8'h00, 4'hf, 8'h22, 8'h02, 8'h00, 4'd2);
    total++; if ({busy, value_out} !== 9'h022) $display("FAIL stall_rob1 got %h want 022", {busy, value_out}); else passed++;
    cycle(0, 0, 1, 1, 0, 8'h00, 4'hf, 8'h33, 8'h03, 8'h00, 4'd3);
    total++; if (busy !== 1'b1) $display("FAIL stall_full_busy got %b want 1", busy); else passed++;
    total++; if ({rob_transmit_out, value_out} !== 9'h000) $display("FAIL stall_ignored got %h want 000", {rob_transmit_out, value_out}); else passed++;
    idle(0, 0);
    total++; if ({cdb_id, cdb_val} !== 12'h111) $display("FAIL stall_drain_a got %h want 111", {cdb_id, cdb_val}); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL stall_busy_same_cycle got %b want 1", busy); else passed++;
    idle(0, 0);
    total++; if ({busy, cdb_id, cdb_val} !== 13'h0222) $display("FAIL stall_drain_b got %h want 0222", {busy, cdb_id, cdb_val}); else passed++;
    idle(0, 0);
    total++; if (cdb_transmit_out !== 1'b0) $display("FAIL stall_no_third got %b want 0", cdb_transmit_out); else passed++;
  endtask
  task automatic test_flush;
    cycle(0, 0, 1, 1, 1, 8'h00, 4'hf, 8'h44, 8'h04, 8'h00, 4'd4);
    cycle(0, 0, 1, 1, 1, 8'h00, 4'hf, 8'h55, 8'h05, 8'h00, 4'd5);
    cycle(0, 1, 1, 0, 0, 8'h00, 4'hf, 8'h66, 8'h06, 8'h00, 4'd6);
    total++; if ({cdb_transmit_out, rob_transmit_out} !== 2'b00) $display("FAIL flush_tx got %b want 00", {cdb_transmit_out, rob_transmit_out}); else passed++;
    total++; if ({cdb_id, cdb_val, value_out} !== 20'h0) $display("FAIL flush_data got %h want 0", {cdb_id, cdb_val, value_out}); else passed++;
    idle(0, 0);
    total++; if ({busy, cdb_transmit_out, rob_transmit_out} !== 3'b000) $display("FAIL flush_after got %b want 000", {busy, cdb_transmit_out, rob_transmit_out}); else passed++;
  endtask
  task automatic test_reset_mid;
    cycle(0, 0, 1, 1, 1, 8'h00, 4'hf, 8'h77, 8'h07, 8'h00, 4'd7);
    cycle(0, 0, 1, 1, 1, 8'h00, 4'hf, 8'h88, 8'h08, 8'h00, 4'd8);
    cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 4'd0);
    total++; if ({cdb_transmit_out, rob_transmit_out, cdb_val, value_out} !== 18'h0) $display("FAIL rstmid_emit got %h want 0", {cdb_transmit_out, rob_transmit_out, cdb_val, value_out}); else passed++;
    idle(0, 0);
    total++; if ({busy, cdb_transmit_out, rob_transmit_out} !== 3'b000) $display("FAIL rstmid_after got %b want 000", {busy, cdb_transmit_out, rob_transmit_out}); else passed++;
  endtask
  task automatic test_random;
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(0, $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
            8'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
      total++; if (busy !== e_busy) $display("FAIL rnd_busy cyc %0d got %b want %b", i, busy, e_busy); else passed++;
      total++; if (cdb_transmit_out !== e_ctx) $display("FAIL rnd_cdb_tx cyc %0d got %b want %b", i, cdb_transmit_out, e_ctx); else passed++;
      total++; if (rob_transmit_out !== e_rtx) $display("FAIL rnd_rob_tx cyc %0d got %b want %b", i, rob_transmit_out, e_rtx); else passed++;
      total++; if ({cdb_id, cdb_val} !== e_cdb) $display("FAIL rnd_cdb cyc %0d got %h want %h", i, {cdb_id, cdb_val}, e_cdb); else passed++;
      total++; if ({robid_out, flags_out, wbs_out, value_out} !== e_rob) $display("FAIL rnd_rob cyc %0d got %h want %h", i, {robid_out, flags_out, wbs_out, value_out}, e_rob); else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_taken();
    test_not_taken();
    test_cdb_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
